// File: rtl/measurement_result_buffer_pkg.sv
// Shared definitions for the measurement result buffer.
// Contents:
//   state_t          - sequencer FSM state encodings
//   COUNT_W_DEFAULT  - default width of the measurement count
//   RESULT_W_DEFAULT - default width of one stored result ({sign, count})
//   result_width()   - result word width for a given count width
package measurement_result_buffer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_CLEAR     = 3'd4
    } state_t;

    localparam int COUNT_W_DEFAULT  = 12;
    localparam int RESULT_W_DEFAULT = COUNT_W_DEFAULT + 1;

    // A stored result carries the reference sign above the count.
    function automatic int result_width(input int count_w);
        return count_w + 1;
    endfunction

endpackage

// File: rtl/measurement_result_buffer_result_fifo.sv
// result_fifo: small synchronous first-word-fall-through FIFO.
// Ports:
//   clk_i, rst_n_i   - clock, synchronous active-low reset (empties the FIFO)
//   wr_en, wr_data   - push request and data; ignored when full unless a pop
//                      happens in the same cycle
//   rd_en            - pop the head entry; ignored when empty
//   rd_data          - head entry, valid whenever empty=0 (reads 0 when empty)
//   level            - occupancy, 0..DEPTH
//   full, empty      - occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module result_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             wr_fire;
    logic             rd_fire;

    assign full    = (level_reg == (AW+1)'(DEPTH));
    assign empty   = (level_reg == '0);
    assign rd_fire = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a write on full is still taken.
    assign wr_fire = wr_en && (!full || rd_fire);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({wr_fire, rd_fire})
                2'b10:   level_reg <= level_reg + (AW+1)'(1);
                2'b01:   level_reg <= level_reg - (AW+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    // Stale storage is masked so an empty FIFO always presents zero.
    assign rd_data = empty ? '0 : mem_reg[rd_ptr_reg];
    assign level   = level_reg;

endmodule

// File: rtl/measurement_result_buffer.sv
// measurement_result_buffer: sequences measurements on digital_top and queues
// the finished results for the host.
// Ports:
//   clk_i, rst_n_i         - clock, synchronous active-low reset
//   start_i, continuous_i  - single-shot request / auto-retrigger level
//   interrupt_i, measurement_count_i, deintegrate_i, ref_sign_i - from digital_top
//   trigger_o, interrupt_clear_o - to digital_top
//   busy_o                 - sequencer not idle
//   rd_en_i, rd_valid_o, rd_data_o, fifo_level_o - FWFT result read port
//   overflow_o, timeout_o  - sticky error flags, cleared by flags_clear_i
module measurement_result_buffer
    import measurement_result_buffer_pkg::*;
#(
    parameter int COUNT_W        = COUNT_W_DEFAULT,
    parameter int FIFO_DEPTH     = 4,
    parameter int TRIG_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 1048575
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          start_i,
    input  logic                          continuous_i,
    input  logic                          interrupt_i,
    input  logic [COUNT_W-1:0]            measurement_count_i,
    input  logic                          deintegrate_i,
    input  logic                          ref_sign_i,
    output logic                          trigger_o,
    output logic                          interrupt_clear_o,
    output logic                          busy_o,
    input  logic                          rd_en_i,
    output logic                          rd_valid_o,
    output logic [COUNT_W:0]              rd_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o,
    output logic                          timeout_o,
    input  logic                          flags_clear_i
);
    localparam int RESULT_W   = result_width(COUNT_W);
    localparam int TRIG_CNT_W = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
    localparam int TMO_CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t                state_reg;
    state_t                state_next;
    logic [TRIG_CNT_W-1:0] trig_cnt_reg;
    logic [TMO_CNT_W-1:0]  tmo_cnt_reg;
    logic                  sign_latch_reg;
    logic                  overflow_reg;
    logic                  timeout_reg;

    logic                  trig_last;
    logic                  tmo_last;
    logic                  enter_trig;
    logic                  timeout_set;
    logic                  overflow_set;
    logic                  rd_pop;

    logic                  fifo_wr_en;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [RESULT_W-1:0]   fifo_wr_data;

    assign trig_last = (trig_cnt_reg == TRIG_CNT_W'(TRIG_CYCLES - 1));
    assign tmo_last  = (tmo_cnt_reg == TMO_CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        trigger_o         = 1'b0;
        interrupt_clear_o = 1'b0;
        fifo_wr_en        = 1'b0;
        busy_o            = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i || (continuous_i && !fifo_full)) begin
                    state_next = ST_TRIG;
                end
            end
            ST_TRIG: begin
                trigger_o = 1'b1;
                if (trig_last) begin
                    state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (interrupt_i) begin
                    state_next = ST_CAPTURE;
                end else if (tmo_last) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CAPTURE: begin
                fifo_wr_en = 1'b1;
                state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                // Hold the acknowledge until digital_top has dropped its interrupt.
                interrupt_clear_o = interrupt_i;
                if (!interrupt_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign enter_trig   = (state_reg == ST_IDLE) && (state_next == ST_TRIG);
    assign timeout_set  = (state_reg == ST_WAIT_DONE) && !interrupt_i && tmo_last;
    assign rd_pop       = rd_en_i && !fifo_empty;
    // A coincident pop makes room, so only a genuinely dropped result flags.
    assign overflow_set = (state_reg == ST_CAPTURE) && fifo_full && !rd_pop;

    // Both counters sit at zero outside their state, which gives the
    // load-on-entry behaviour without a separate load strobe.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            trig_cnt_reg <= '0;
            tmo_cnt_reg  <= '0;
        end else begin
            trig_cnt_reg <= (state_reg == ST_TRIG) ? trig_cnt_reg + TRIG_CNT_W'(1) : '0;
            tmo_cnt_reg  <= (state_reg == ST_WAIT_DONE) ? tmo_cnt_reg + TMO_CNT_W'(1) : '0;
        end
    end

    // The sign is tracked during deintegration and frozen once it ends, so the
    // value captured later belongs to the current measurement.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sign_latch_reg <= 1'b0;
        end else if (enter_trig) begin
            sign_latch_reg <= 1'b0;
        end else if (deintegrate_i) begin
            sign_latch_reg <= ref_sign_i;
        end
    end

    // Sticky flags: a set event in the same cycle as a clear request wins.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            overflow_reg <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow_reg <= 1'b1;
            end else if (flags_clear_i) begin
                overflow_reg <= 1'b0;
            end
            if (timeout_set) begin
                timeout_reg <= 1'b1;
            end else if (flags_clear_i) begin
                timeout_reg <= 1'b0;
            end
        end
    end

    assign fifo_wr_data = {sign_latch_reg, measurement_count_i};

    result_fifo #(
        .WIDTH (RESULT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .wr_en   (fifo_wr_en),
        .wr_data (fifo_wr_data),
        .rd_en   (rd_en_i),
        .rd_data (rd_data_o),
        .level   (fifo_level_o),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rd_valid_o = !fifo_empty;
    assign overflow_o = overflow_reg;
    assign timeout_o  = timeout_reg;

endmodule
